frame_streamer: RTL and testbench
=================================

# frame_streamer

Output stage of the image pipeline. It sits directly downstream of the mirror/grayscale/sharpen processor. After `start` (wired from the processor's `filter_done`), it scans the processed 64x64 RGB output image through the same row/col read port style the processor uses. It then streams every pixel in raster order over a valid/ready interface, with frame and line markers, buffered through a small FIFO so backpressure never loses or repeats a pixel.

## Interface
Parameters:
- `IMG_W`, 64: pixels per row; power of two, at most 64.
- `IMG_H`, 64: rows per frame; power of two, at most 64.
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, at least 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: one-cycle pulse that begins a frame; ignored while `busy`.
- `row`, out, 6: read row address to the output image memory; registered.
- `col`, out, 6: read column address to the output image memory; registered.
- `in_pix`, in, 24: pixel at [`row`,`col`] (R 23:16, G 15:8, B 7:0); combinational read, valid in the same cycle as the address.
- `m_valid`, out, 1: stream data valid.
- `m_ready`, in, 1: downstream accepts the beat.
- `m_data`, out, 24: pixel value.
- `m_sof`, out, 1: beat is pixel [0,0].
- `m_eol`, out, 1: beat is the last column of a row.
- `m_eof`, out, 1: beat is pixel [IMG_H-1, IMG_W-1].
- `busy`, out, 1: frame in progress.
- `done`, out, 1: one-cycle pulse when the frame has been fully accepted.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- **IDLE**: `row`=`col`=0. `start` moves to FETCH; `busy` rises the next cycle.
- **FETCH**: push condition is FIFO count < FIFO_DEPTH.
  - On push, write {`in_pix`, sof, eol, eof} into the FIFO. Markers are computed from the current `row`/`col`.
  - Then advance `col`. When `col` reaches IMG_W-1, wrap `col` to 0 and increment `row`.
  - The push of [IMG_H-1, IMG_W-1] moves to DRAIN and leaves `row`/`col` at 0.
  - When the FIFO is full, the address holds and no push occurs.
- **DRAIN**: no pushes. Move to DONE on the handshake of the `m_eof` beat.
- **DONE**: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- **FIFO behaviour**:
  - `m_valid` = FIFO not empty. `m_data` and the markers are driven from the FIFO head.
  - A pop occurs when `m_valid` and `m_ready` are both high.
  - A push and a pop in the same cycle leave the count unchanged. A push into a full FIFO never happens.
- Each frame produces exactly IMG_W*IMG_H beats, in order, with no duplicates.
- `m_sof` and `m_eof` each occur once per frame. `m_eol` occurs IMG_H times.
- **Corner cases**:
  - `start` while `busy` has no effect, including in the DONE cycle.
  - `m_ready` held low stalls indefinitely. Data and markers are held stable while `m_valid`=1.
  - Asserting `rst_n` low mid-frame immediately clears all state: the FIFO is emptied, the partial frame is discarded, and no `done` is produced.

## Timing
- Reset values: `row`=0, `col`=0, `m_valid`=0, `m_data`=0, `m_sof`=`m_eol`=`m_eof`=0, `busy`=0, `done`=0.
- Cycle numbering: `start` is sampled high at edge 0.
  - Cycle 1: FETCH, first push of [0,0].
  - Cycle 2: `m_valid`=1 with `m_sof`=1.
- With `m_ready` held high, throughput is one beat per cycle.
  - The last beat is presented in cycle IMG_W*IMG_H+1.
  - `done` pulses in the cycle after that beat's handshake. For 64x64, the `m_eof` handshake is in cycle 4097 and `done` is in cycle 4098.
- `m_valid` never drops without a pop, and the data never changes without a pop.

## Structure
- Shared package `img_pkg`:
  - Constants IMG_W and IMG_H.
  - Pixel type (24-bit) and channel slice positions.
  - Stream beat struct {pix, sof, eol, eof}.
  - State enum.
- Sub-module `sync_fifo` (parameterised width and depth; count, full, empty). The streamer contains only the address counters, the FSM and the marker logic.

## Test plan
- **Full-speed frame**: memory pattern pix = {row, col, row^col} with 2-bit zero padding per channel, `m_ready`=1, single `start`.
  - 4096 beats in raster order.
  - `m_sof` on the first beat, `m_eol` every 64th beat, `m_eof` on beat 4096.
  - `done` in cycle 4098.
- **Random backpressure** (`m_ready` random, 30% low): the sequence is identical to the full-speed case. Data is stable whenever `m_valid`=1 and `m_ready`=0. `row`/`col` freeze while the FIFO is full.
- **Long stall**: `m_ready`=0 for 100 cycles from cycle 0. The FIFO holds exactly 4 entries, `row`/`col` stop at [0,4], and on release beats 0..4095 follow with no gaps or duplicates.
- **Start while busy**: a second `start` at cycle 50 and in the DONE cycle yields exactly one frame and one `done` pulse.
- **Mid-frame reset**: pull `rst_n` low at beat 1000.
  - All outputs return to reset values in the same cycle.
  - A fresh `start` produces a full 4096-beat frame beginning at [0,0] with `m_sof`.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline types: frame geometry, pixel layout, stream beat and
// the streamer state encoding.
package img_pkg;

  localparam int unsigned IMG_W  = 64;
  localparam int unsigned IMG_H  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PIX_W  = 24;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned R_LSB  = 16;
  localparam int unsigned G_LSB  = 8;
  localparam int unsigned B_LSB  = 0;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t pix;
    logic sof;
    logic eol;
    logic eof;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  // Build one stream beat from a pixel and its raster position flags.
  function automatic beat_t make_beat(input pix_t pix, input logic first,
                                      input logic last_col, input logic last_row);
    beat_t b;
    b.pix = pix;
    b.sof = first;
    b.eol = last_col;
    b.eof = last_col & last_row;
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is visible on rdata
// whenever the FIFO is not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// Scans the processed image in raster order and streams it over valid/ready
// with frame/line markers, decoupled by a small prefetch FIFO.
module frame_streamer #(
  parameter int unsigned IMG_W      = img_pkg::IMG_W,
  parameter int unsigned IMG_H      = img_pkg::IMG_H,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [5:0]  row,
  output logic [5:0]  col,
  input  logic [23:0] in_pix,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [23:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        m_eof,
  output logic        busy,
  output logic        done
);

  import img_pkg::*;

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W = $bits(beat_t);

  state_t           state_q;
  state_t           state_d;
  logic [5:0]       row_d;
  logic [5:0]       col_d;
  logic             busy_d;
  logic             done_d;
  logic             push_c;
  logic             pop_c;
  logic             last_col_c;
  logic             last_row_c;
  beat_t            wr_beat;
  beat_t            rd_beat;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;

  assign last_col_c = (col == 6'(IMG_W - 1));
  assign last_row_c = (row == 6'(IMG_H - 1));
  assign wr_beat    = make_beat(pix_t'(in_pix), (row == '0) && (col == '0),
                                last_col_c, last_row_c);

  assign m_valid = ~fifo_empty;
  assign pop_c   = m_valid & m_ready;
  assign m_data  = rd_beat.pix;
  assign m_sof   = rd_beat.sof;
  assign m_eol   = rd_beat.eol;
  assign m_eof   = rd_beat.eof;

  sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .wdata (wr_beat),
    .pop   (pop_c),
    .rdata (rd_beat),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, address advance and push decision.
  always_comb begin
    state_d = state_q;
    row_d   = row;
    col_d   = col;
    push_c  = 1'b0;
    case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (fifo_cnt < CNT_W'(FIFO_DEPTH)) begin
          push_c = 1'b1;
          if (last_col_c) begin
            col_d = '0;
            if (last_row_c) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row + 6'd1;
            end
          end else begin
            col_d = col + 6'd1;
          end
        end
      end
      DRAIN: begin
        if (pop_c && rd_beat.eof) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == FETCH) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row     <= '0;
      col     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row     <= row_d;
      col     <= col_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_c && fifo_full));

endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer against a raster/occupancy model.
`timescale 1ns/1ps
module tb_frame_streamer;

  localparam int W     = 64;
  localparam int H     = 64;
  localparam int NPIX  = W * H;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [23:0] in_pix;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_eof;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  int r_beats, r_seq_err, r_stab_err, r_addr_err, r_valid_err, r_busy_err, r_done_err;
  int r_sof, r_eol, r_eof, r_done, r_done_cyc, r_hs_cyc, r_timeout, r_bad_idx;
  int r_snap_row, r_snap_col, r_snap_valid;
  logic [26:0] r_bad_got, r_bad_exp;

  always #5 clk = ~clk;

  // Output image memory: R={row,00}, G={col,00}, B={row^col,00}.
  assign in_pix = {row, 2'b00, col, 2'b00, row ^ col, 2'b00};

  frame_streamer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .row     (row),
    .col     (col),
    .in_pix  (in_pix),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_sof   (m_sof),
    .m_eol   (m_eol),
    .m_eof   (m_eof),
    .busy    (busy),
    .done    (done)
  );

  function automatic logic [23:0] exp_pix(input int idx);
    logic [5:0] r;
    logic [5:0] c;
    r = 6'(idx / W);
    c = 6'(idx % W);
    return {r, 2'b00, c, 2'b00, r ^ c, 2'b00};
  endfunction

  // Drives one frame from a start pulse, tracking expected addresses and
  // beats from the count of pixels fetched and accepted so far.
  task automatic stream_frame(input int low_pct, input int stall, input int dup_cyc,
                              input int abort_at);
    int cyc, mpush, mpop, cnt, idx;
    bit rdy, prev_valid, prev_rdy;
    logic [26:0] prev_beat, cur_beat, exp_beat;
    r_seq_err = 0; r_stab_err = 0; r_addr_err = 0; r_valid_err = 0; r_busy_err = 0;
    r_done_err = 0; r_sof = 0; r_eol = 0; r_eof = 0; r_done = 0; r_done_cyc = -1;
    r_hs_cyc = -1; r_timeout = 0; r_bad_idx = -1; r_bad_got = '0; r_bad_exp = '0;
    r_snap_row = -1; r_snap_col = -1; r_snap_valid = -1;
    prev_valid = 1'b0; prev_rdy = 1'b1; prev_beat = '0;
    start   = 1'b1;
    m_ready = (stall > 0) ? 1'b0 : 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; mpush = 0; mpop = 0;
    forever begin
      cnt = mpush - mpop;
      if (abort_at >= 0 && mpop == abort_at) break;
      idx = (mpush < NPIX) ? mpush : 0;
      if (row !== 6'(idx / W) || col !== 6'(idx % W)) r_addr_err++;
      if (cyc == stall - 1) begin
        r_snap_row = int'(row); r_snap_col = int'(col); r_snap_valid = int'(m_valid);
      end
      if (m_valid !== (cnt > 0)) r_valid_err++;
      cur_beat = {m_data, m_sof, m_eol, m_eof};
      if (cnt > 0) begin
        exp_beat = {exp_pix(mpop), mpop == 0, (mpop % W) == W - 1, mpop == NPIX - 1};
        if (cur_beat !== exp_beat) begin
          if (r_seq_err == 0) begin
            r_bad_idx = mpop; r_bad_got = cur_beat; r_bad_exp = exp_beat;
          end
          r_seq_err++;
        end
      end
      if (prev_valid && !prev_rdy && (m_valid !== 1'b1 || cur_beat !== prev_beat))
        r_stab_err++;
      if (busy !== (r_hs_cyc < 0)) r_busy_err++;
      if (done !== (r_hs_cyc >= 0 && cyc == r_hs_cyc + 1)) r_done_err++;
      if (done === 1'b1) begin
        r_done++;
        r_done_cyc = cyc;
      end
      if (r_done_cyc > 0 && cyc >= r_done_cyc + 4) break;
      if (cyc >= 30000) begin
        r_timeout = 1;
        break;
      end
      rdy     = (cyc >= stall) && ($urandom_range(99) >= low_pct);
      m_ready = rdy;
      start   = (cyc == dup_cyc) || (dup_cyc >= 0 && done === 1'b1);
      if (cnt > 0 && rdy) begin
        if (m_sof === 1'b1) r_sof++;
        if (m_eol === 1'b1) r_eol++;
        if (m_eof === 1'b1) r_eof++;
        if (mpop == NPIX - 1) r_hs_cyc = cyc;
        mpop++;
      end
      if (mpush < NPIX && cnt < DEPTH) mpush++;
      prev_valid = m_valid; prev_rdy = rdy; prev_beat = cur_beat;
      @(negedge clk);
      cyc++;
    end
    r_beats = mpop;
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({row, col} !== 12'd0) begin
      n_fail++; $display("FAIL reset_addr: got row %0d col %0d expected 0 0", row, col);
    end
    n_checks++;
    if ({m_valid, m_sof, m_eol, m_eof} !== 4'd0) begin
      n_fail++; $display("FAIL reset_stream_ctrl: got %b expected 0000", {m_valid, m_sof, m_eol, m_eof});
    end
    n_checks++;
    if (m_data !== 24'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 000000", m_data);
    end
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, m_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_no_start: got %b expected 000", {busy, m_valid, done});
    end
  endtask

  task automatic test_full_speed();
    stream_frame(0, 0, -1, -1);
    n_checks++;
    if (r_timeout != 0) begin n_fail++; $display("FAIL fs_timeout: got %0d expected 0", r_timeout); end
    n_checks++;
    if (r_beats != NPIX) begin n_fail++; $display("FAIL fs_beats: got %0d expected %0d", r_beats, NPIX); end
    n_checks++;
    if (r_seq_err != 0) begin
      n_fail++; $display("FAIL fs_sequence: %0d bad beats, first idx %0d got %h expected %h",
                         r_seq_err, r_bad_idx, r_bad_got, r_bad_exp);
    end
    n_checks++;
    if (r_sof != 1 || r_eol != H || r_eof != 1) begin
      n_fail++; $display("FAIL fs_markers: got sof %0d eol %0d eof %0d expected 1 %0d 1", r_sof, r_eol, r_eof, H);
    end
    n_checks++;
    if (r_hs_cyc != NPIX + 1) begin n_fail++; $display("FAIL fs_eof_cycle: got %0d expected %0d", r_hs_cyc, NPIX + 1); end
    n_checks++;
    if (r_done_cyc != NPIX + 2) begin n_fail++; $display("FAIL fs_done_cycle: got %0d expected %0d", r_done_cyc, NPIX + 2); end
    n_checks++;
    if (r_addr_err + r_valid_err + r_busy_err + r_done_err != 0) begin
      n_fail++; $display("FAIL fs_timing: got addr %0d valid %0d busy %0d done %0d errors expected 0",
                         r_addr_err, r_valid_err, r_busy_err, r_done_err);
    end
  endtask

  task automatic test_backpressure();
    stream_frame(30, 0, -1, -1);
    n_checks++;
    if (r_beats != NPIX || r_timeout != 0) begin
      n_fail++; $display("FAIL bp_beats: got %0d (timeout %0d) expected %0d", r_beats, r_timeout, NPIX);
    end
    n_checks++;
    if (r_seq_err != 0) begin
      n_fail++; $display("FAIL bp_sequence: %0d bad beats, first idx %0d got %h expected %h",
                         r_seq_err, r_bad_idx, r_bad_got, r_bad_exp);
    end
    n_checks++;
    if (r_stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable beats expected 0", r_stab_err); end
    n_checks++;
    if (r_addr_err != 0) begin n_fail++; $display("FAIL bp_addr_freeze: got %0d address errors expected 0", r_addr_err); end
    n_checks++;
    if (r_done != 1 || r_done_cyc != r_hs_cyc + 1 || r_done_err != 0) begin
      n_fail++; $display("FAIL bp_done: got %0d pulses at %0d (eof hs %0d) expected 1 at hs+1", r_done, r_done_cyc, r_hs_cyc);
    end
  endtask

  task automatic test_long_stall();
    stream_frame(0, 100, -1, -1);
    n_checks++;
    if (r_snap_row != 0 || r_snap_col != DEPTH || r_snap_valid != 1) begin
      n_fail++; $display("FAIL stall_hold: got row %0d col %0d valid %0d expected 0 %0d 1",
                         r_snap_row, r_snap_col, r_snap_valid, DEPTH);
    end
    n_checks++;
    if (r_beats != NPIX || r_seq_err != 0 || r_stab_err != 0) begin
      n_fail++; $display("FAIL stall_sequence: got %0d beats, %0d bad, %0d unstable expected %0d 0 0",
                         r_beats, r_seq_err, r_stab_err, NPIX);
    end
    n_checks++;
    if (r_hs_cyc != NPIX + 99 || r_addr_err + r_valid_err != 0) begin
      n_fail++; $display("FAIL stall_no_gaps: got eof hs %0d addr err %0d valid err %0d expected %0d 0 0",
                         r_hs_cyc, r_addr_err, r_valid_err, NPIX + 99);
    end
  endtask

  task automatic test_start_busy();
    stream_frame(10, 0, 50, -1);
    n_checks++;
    if (r_done != 1 || r_done_err != 0) begin
      n_fail++; $display("FAIL sb_done_pulses: got %0d pulses, %0d errors expected 1 0", r_done, r_done_err);
    end
    n_checks++;
    if (r_beats != NPIX || r_sof != 1 || r_seq_err != 0) begin
      n_fail++; $display("FAIL sb_one_frame: got %0d beats sof %0d bad %0d expected %0d 1 0", r_beats, r_sof, r_seq_err, NPIX);
    end
    n_checks++;
    if (r_busy_err + r_valid_err + r_addr_err != 0) begin
      n_fail++; $display("FAIL sb_no_restart: got busy %0d valid %0d addr %0d errors expected 0",
                         r_busy_err, r_valid_err, r_addr_err);
    end
  endtask

  task automatic test_mid_reset();
    stream_frame(20, 0, -1, 1000);
    n_checks++;
    if (r_beats != 1000 || r_seq_err != 0) begin
      n_fail++; $display("FAIL mr_partial: got %0d beats %0d bad expected 1000 0", r_beats, r_seq_err);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({row, col, m_data} !== 36'd0 || {m_valid, m_sof, m_eol, m_eof, busy, done} !== 6'd0) begin
      n_fail++; $display("FAIL mr_reset_outputs: got row %0d col %0d data %h ctrl %b expected all 0",
                         row, col, m_data, {m_valid, m_sof, m_eol, m_eof, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, m_valid} !== 3'b000) begin
      n_fail++; $display("FAIL mr_no_done: got %b expected 000", {busy, done, m_valid});
    end
    stream_frame(0, 0, -1, -1);
    n_checks++;
    if (r_beats != NPIX || r_seq_err != 0 || r_sof != 1 || r_eof != 1) begin
      n_fail++; $display("FAIL mr_fresh_frame: got %0d beats %0d bad sof %0d eof %0d expected %0d 0 1 1",
                         r_beats, r_seq_err, r_sof, r_eof, NPIX);
    end
    n_checks++;
    if (r_done_cyc != NPIX + 2) begin n_fail++; $display("FAIL mr_done_cycle: got %0d expected %0d", r_done_cyc, NPIX + 2); end
  endtask

  initial begin
    test_reset();
    test_full_speed();
    test_backpressure();
    test_long_stall();
    test_start_busy();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
